mod_sequencer: RTL and testbench
================================

# mod_sequencer

Multi-cycle, register-mapped remainder/quotient engine for unsigned 16-bit operands. Software writes X and Y, writes START to the control register, then polls status or watches DONE and reads the packed {quotient, remainder} result. One restoring-division step is computed per clock, so a single shared 16-bit subtractor replaces a combinational divider in the processor's arithmetic peripheral space.

## Interface
- DATA_W, 16, operand width; quotient and remainder each DATA_W bits.
- ITER, DATA_W, iteration count; fixed equal to DATA_W.

- CLK  in  1  single clock; all state changes on posedge.
- RST_N  in  1  asynchronous, active-low reset.
- E  in  1  enable; when low, W and R are ignored and the FSM keeps running.
- W  in  1  register write strobe, sampled on posedge.
- R  in  1  register read strobe, sampled on posedge.
- ADDR  in  2  0=X, 1=Y, 2=RESULT (read-only), 3=CTRL/STATUS.
- D  in  16  write data.
- OUT  out  32  registered read data.
- BUSY  out  1  operation in progress.
- DONE  out  1  sticky completion flag.

## Operation
- Reset: X=Y=0, RESULT=0, OUT=0, BUSY=0, DONE=0, DZ=0, state IDLE.
- Writes (E&W): addr 0→X, addr 1→Y, addr 2 ignored, addr 3 bit0=START. X/Y writes are accepted at any time and never affect an operation already latched.
- Reads (E&R): OUT <= {16'b0,X}, {16'b0,Y}, {Q,REM}, or {29'b0,DZ,DONE,BUSY} for addr 0..3. Read-then-write on the same edge returns the pre-write value.
- FSM states:
  - IDLE: START→LOAD.
  - LOAD: latch dividend shift register q=X, divisor d=Y, rem=0, cnt=0; clear DONE and DZ; BUSY=1. If Y==0, go to FIN with DZ=1; otherwise go to ITER.
  - ITER: rem' = {rem[15:0], q[15]}, q <<= 1. If rem' >= {1'b0,d}: rem = rem'-d and q[0]=1. cnt++. After the 16th step, go to FIN.
  - FIN: RESULT <= {q, rem[15:0]}, or {16'hFFFF, X_latched} when DZ. BUSY=0, DONE=1, go to IDLE.
- START while BUSY: ignored; no restart, no flag change.
- START in IDLE with DONE=1: starts a new operation; DONE clears in LOAD.
- rem is 17 bits internally so the compare cannot overflow; RESULT holds its value until the next FIN.

## Timing
- START write at edge t: LOAD at edge t+1 (BUSY=1), ITER at edges t+2..t+17, FIN at edge t+18. DONE=1 and RESULT valid after edge t+18.
- Nominal latency from START edge to DONE: 18 cycles. Divide-by-zero latency: 2 cycles.
- A read of addr 2 issued at edge t+18 returns the old RESULT. The earliest read returning the new RESULT is at edge t+19.
- BUSY and DONE are registered outputs and never both 1.
- Asserting RST_N low mid-operation clears everything immediately. No result is written, and the operation is not resumed after reset deasserts.

## Structure
- Package mod_seq_pkg: ADDR_X/ADDR_Y/ADDR_RESULT/ADDR_CTRL constants, DATA_W, state enum {IDLE, LOAD, ITER, FIN}, status bit indices (BUSY=0, DONE=1, DZ=2).
- Sub-module mod_divstep, purely combinational:
  - Inputs: rem, q, d.
  - Outputs: next rem and next q for one restoring step.
- The top level holds the register file, FSM, counter and read mux.

## Test plan
- X=5, Y=4, START. After 18 cycles: DONE=1, read addr 2 → 0x00010001, status → 0x2.
- X=445, Y=100, START. Read addr 2 → 0x0004002D. BUSY must be high for exactly 17 cycles (LOAD + 16 ITER).
- X=65535, Y=65535 → 0x00010000. Then X=65535, Y=1 → 0xFFFF0000.
- X=7, Y=0, START. DONE after 2 cycles, status → 0x6, read addr 2 → 0xFFFF0007.
- Start X=445, Y=100. Mid-operation, write X=9, Y=2 and START again. The result is still 0x0004002D, with no DONE before cycle 18. A following START gives 0x00040001.
- Pull RST_N low at ITER cycle 8: OUT, BUSY and DONE are 0 immediately, and RESULT reads 0 after reset is released.

Source files
------------

// File: rtl/mod_seq_pkg.sv
// Shared constants and types for the register-mapped
// restoring divider (mod_sequencer).
package mod_seq_pkg;

  localparam int DATA_W = 16;
  localparam int N_ITER = DATA_W;
  localparam int CNT_W  = $clog2(N_ITER + 1);

  localparam logic [1:0] ADDR_X      = 2'd0;
  localparam logic [1:0] ADDR_Y      = 2'd1;
  localparam logic [1:0] ADDR_RESULT = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_DZ   = 2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ITER,
    FIN
  } state_e;

endpackage

// File: rtl/mod_sequencer_if.sv
// Register bus between a processor-side master and the
// divider peripheral.
interface mod_sequencer_if;
  import mod_seq_pkg::*;

  logic                  E;
  logic                  W;
  logic                  R;
  logic [1:0]            ADDR;
  logic [DATA_W-1:0]     D;
  logic [2*DATA_W-1:0]   OUT;
  logic                  BUSY;
  logic                  DONE;

  modport master (
    output E, W, R, ADDR, D,
    input  OUT, BUSY, DONE
  );

  modport slave (
    input  E, W, R, ADDR, D,
    output OUT, BUSY, DONE
  );

endinterface

// File: rtl/mod_divstep.sv
// One restoring-division step: shift in the next dividend
// bit, subtract the divisor when it fits.
module mod_divstep
  import mod_seq_pkg::*;
(
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] q_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W:0] rem_sh;
  logic            ge;

  assign rem_sh = {rem_i, q_i[DATA_W-1]};
  assign ge     = rem_sh >= {1'b0, d_i};

  // when ge, the true difference is < d, so it fits
  // in DATA_W bits and the wrapped subtract is exact
  assign rem_o = ge ? rem_sh[DATA_W-1:0] - d_i
                    : rem_sh[DATA_W-1:0];
  assign q_o   = {q_i[DATA_W-2:0], ge};

endmodule

// File: rtl/mod_sequencer.sv
// Register file, control FSM and read mux of the
// multi-cycle 16-bit quotient/remainder engine.
module mod_sequencer (
  input  logic           CLK,
  input  logic           RST_N,
  mod_sequencer_if.slave bus
);
  import mod_seq_pkg::*;

  localparam int RW = 2 * DATA_W;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] div_q, div_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RW-1:0]     res_q, res_d;
  logic [RW-1:0]     out_q, out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              dz_q, dz_d;

  logic              wr;
  logic              rd;
  logic              start;
  logic [RW-1:0]     status;
  logic [DATA_W-1:0] step_rem;
  logic [DATA_W-1:0] step_q;

  assign wr    = bus.E & bus.W;
  assign rd    = bus.E & bus.R;
  assign start = wr && (bus.ADDR == ADDR_CTRL) && bus.D[0];

  mod_divstep u_step (
    .rem_i (rem_q),
    .q_i   (q_q),
    .d_i   (div_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_comb begin
    status          = '0;
    status[ST_BUSY] = busy_q;
    status[ST_DONE] = done_q;
    status[ST_DZ]   = dz_q;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    q_d     = q_q;
    rem_d   = rem_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = done_q;
    dz_d    = dz_q;

    if (rd) begin
      unique case (bus.ADDR)
        ADDR_X:      out_d = {{DATA_W{1'b0}}, x_q};
        ADDR_Y:      out_d = {{DATA_W{1'b0}}, y_q};
        ADDR_RESULT: out_d = res_q;
        ADDR_CTRL:   out_d = status;
      endcase
    end

    if (wr && bus.ADDR == ADDR_X) x_d = bus.D;
    if (wr && bus.ADDR == ADDR_Y) y_d = bus.D;

    unique case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        q_d     = x_q;
        div_d   = y_q;
        rem_d   = '0;
        cnt_d   = '0;
        done_d  = 1'b0;
        busy_d  = 1'b1;
        dz_d    = (y_q == '0);
        state_d = (y_q == '0) ? FIN : ITER;
      end
      ITER: begin
        q_d   = step_q;
        rem_d = step_rem;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N_ITER - 1)) state_d = FIN;
      end
      FIN: begin
        // q still holds the latched dividend on div-by-zero
        res_d   = dz_q ? {{DATA_W{1'b1}}, q_q}
                       : {q_q, rem_q};
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.OUT  = out_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;

endmodule

// File: tb/tb_mod_sequencer.sv
// Scoreboard bench for mod_sequencer: expected results are
// queued at START and compared when RESULT is read back.
module tb_mod_sequencer;
  import mod_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mod_sequencer_if bus ();

  mod_sequencer dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  bit          both_seen = 1'b0;
  logic [31:0] sb[$];
  logic [31:0] v;
  int          lat;
  int          bn;

  always @(negedge clk)
    if (bus.BUSY === 1'b1 && bus.DONE === 1'b1)
      both_seen = 1'b1;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               tag, got, exp);
    end
  endtask

  task automatic wr(logic [1:0] a, logic [15:0] d);
    bus.E = 1'b1; bus.W = 1'b1;
    bus.ADDR = a; bus.D = d;
    @(negedge clk);
    bus.E = 1'b0; bus.W = 1'b0;
  endtask

  task automatic rd(logic [1:0] a, output logic [31:0] q);
    bus.E = 1'b1; bus.R = 1'b1; bus.ADDR = a;
    @(negedge clk);
    bus.E = 1'b0; bus.R = 1'b0;
    q = bus.OUT;
  endtask

  // k0 = number of edges already elapsed since START
  task automatic wait_done(int k0, output int l,
                           output int b);
    l = 0;
    b = 0;
    for (int k = k0; k <= 40; k++) begin
      @(negedge clk);
      if (bus.BUSY === 1'b1) b++;
      if (bus.DONE === 1'b1) begin
        l = k;
        break;
      end
    end
  endtask

  task automatic check_result(string tag);
    logic [31:0] got;
    logic [31:0] exp;
    rd(ADDR_RESULT, got);
    if (sb.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: got 0x%08h expected none queued",
               tag, got);
    end else begin
      exp = sb.pop_front();
      chk(tag, got, exp);
    end
  endtask

  task automatic run(logic [15:0] x, logic [15:0] y,
                     logic [31:0] exp, int e_lat,
                     int e_busy, string tag);
    int l;
    int b;
    wr(ADDR_X, x);
    wr(ADDR_Y, y);
    sb.push_back(exp);
    wr(ADDR_CTRL, 16'h1);
    wait_done(1, l, b);
    chk({tag, "_lat"}, l, e_lat);
    chk({tag, "_busy"}, b, e_busy);
    check_result({tag, "_res"});
  endtask

  initial begin
    bus.E = 1'b0; bus.W = 1'b0; bus.R = 1'b0;
    bus.ADDR = '0; bus.D = '0;
    repeat (2) @(negedge clk);
    chk("rst_out", bus.OUT, 0);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_done", bus.DONE, 0);
    rst_n = 1'b1;
    @(negedge clk);
    sb.push_back(32'h0);
    check_result("rst_res");
    rd(ADDR_CTRL, v);
    chk("rst_status", v, 0);

    bus.E = 1'b1; bus.W = 1'b1; bus.R = 1'b1;
    bus.ADDR = ADDR_X; bus.D = 16'h1234;
    @(negedge clk);
    bus.E = 1'b0; bus.W = 1'b0; bus.R = 1'b0;
    chk("rw_old", bus.OUT, 0);
    rd(ADDR_X, v);
    chk("rw_new", v, 32'h1234);

    run(16'd5, 16'd4, 32'h0001_0001, 18, 17, "d5_4");
    rd(ADDR_CTRL, v);
    chk("d5_4_status", v, 32'h2);
    run(16'd445, 16'd100, 32'h0004_002D, 18, 17, "d445");
    run(16'hFFFF, 16'hFFFF, 32'h0001_0000, 18, 17, "dff_ff");
    run(16'hFFFF, 16'h0001, 32'hFFFF_0000, 18, 17, "dff_1");
    run(16'd7, 16'd0, 32'hFFFF_0007, 2, 1, "dz");
    rd(ADDR_CTRL, v);
    chk("dz_status", v, 32'h6);

    // writes and START during an operation are ignored
    wr(ADDR_X, 16'd445);
    wr(ADDR_Y, 16'd100);
    sb.push_back(32'h0004_002D);
    wr(ADDR_CTRL, 16'h1);
    wr(ADDR_X, 16'd9);
    wr(ADDR_Y, 16'd2);
    wr(ADDR_CTRL, 16'h1);
    wait_done(4, lat, bn);
    chk("busy_start_lat", lat, 18);
    check_result("busy_start_res");
    sb.push_back(32'h0004_0001);
    wr(ADDR_CTRL, 16'h1);
    wait_done(1, lat, bn);
    chk("restart_lat", lat, 18);
    check_result("restart_res");

    // reset during ITER step 8
    wr(ADDR_X, 16'd445);
    wr(ADDR_Y, 16'd100);
    wr(ADDR_CTRL, 16'h1);
    @(negedge clk);
    rd(ADDR_CTRL, v);
    chk("mid_status", v, 32'h1);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", bus.OUT, 0);
    chk("mid_rst_busy", bus.BUSY, 0);
    chk("mid_rst_done", bus.DONE, 0);
    sb.push_back(32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_result("mid_rst_res");
    repeat (20) @(negedge clk);
    chk("no_resume_done", bus.DONE, 0);
    rd(ADDR_CTRL, v);
    chk("no_resume_status", v, 0);

    chk("busy_done_excl", 32'(both_seen), 0);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
